parking_gate_ctrl: RTL and testbench

Controller for a single-lane parking ramp shared by an entry gate and an exit gate. It arbitrates lane access between the waiting entry car and the waiting exit car, and sequences the shared barrier (raise, pass, lower) with timeouts. It also owns the occupancy count and the full/empty flags that the counter block provides today. It sits between the loop sensors, the barrier actuator, and the lot display logic.

---
 rtl/parking_gate_ctrl_pkg.sv | 17 +
 rtl/parking_gate_ctrl_rr_arb.sv | 22 ++
 rtl/parking_gate_ctrl.sv | 152 +++++++++++++++
 tb/tb_parking_gate_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parking_gate_ctrl_pkg.sv
// Shared definitions for the parking ramp controller: FSM state encoding
// and default sizing for the lot and the barrier timeouts.
package parking_gate_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RAISE = 3'd1,
    ST_PASS  = 3'd2,
    ST_LOWER = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  localparam int DEF_CAPACITY = 10;
  localparam int DEF_CNT_W    = 4;
  localparam int DEF_TIMEOUT  = 16;

endpackage

// File: rtl/parking_gate_ctrl_rr_arb.sv
// Two-requester round-robin arbiter for the shared ramp. Purely combinational;
// the history bit (last_in) is owned by the caller.
module parking_rr_arb (
  input  logic       req_in,
  input  logic       req_out,
  input  logic       last_in,
  output logic [1:0] grant
);

  // grant[0] = entry lane, grant[1] = exit lane
  always_comb begin
    grant = 2'b00;
    if (req_in && req_out) begin
      grant = last_in ? 2'b10 : 2'b01;
    end else if (req_in) begin
      grant = 2'b01;
    end else if (req_out) begin
      grant = 2'b10;
    end
  end

endmodule

// File: rtl/parking_gate_ctrl.sv
// Single-lane parking ramp controller: arbitrates entry/exit, sequences the
// barrier (raise, pass, lower) with timeouts, and keeps the occupancy count.
module parking_gate_ctrl
  import parking_gate_ctrl_pkg::*;
#(
  parameter int CAPACITY = DEF_CAPACITY,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_req,
  input  logic             out_req,
  input  logic             bar_up,
  input  logic             bar_down,
  input  logic             car_pass,
  output logic             barrier_open,
  output logic             grant_in,
  output logic             grant_out,
  output logic             in_denied,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             timeout_err,
  output logic             fault,
  output state_t           fsm_state
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CAP      = CNT_W'(CAPACITY);

  state_t           state, state_next;
  logic [TMR_W-1:0] timer;
  logic             last_in, last_in_next;
  logic [CNT_W-1:0] count_next;
  logic             open_next, gin_next, gout_next, to_next, fault_next;
  logic [1:0]       grant;
  logic             timed_out;

  assign timed_out = (timer == TMR_LAST);
  assign full      = (count == CAP);
  assign empty     = (count == '0);
  assign in_denied = (state == ST_IDLE) && in_req && full;
  assign fsm_state = state;

  parking_rr_arb u_arb (
    .req_in  (in_req && !full),
    .req_out (out_req && !empty),
    .last_in (last_in),
    .grant   (grant)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      timer        <= '0;
      last_in      <= 1'b0;
      count        <= '0;
      barrier_open <= 1'b0;
      grant_in     <= 1'b0;
      grant_out    <= 1'b0;
      timeout_err  <= 1'b0;
      fault        <= 1'b0;
    end else begin
      state        <= state_next;
      last_in      <= last_in_next;
      count        <= count_next;
      barrier_open <= open_next;
      grant_in     <= gin_next;
      grant_out    <= gout_next;
      timeout_err  <= to_next;
      fault        <= fault_next;
      // Timer restarts on every state change so each phase gets its full budget
      if (state_next != state) begin
        timer <= '0;
      end else if (state == ST_RAISE || state == ST_PASS || state == ST_LOWER) begin
        timer <= timer + TMR_W'(1);
      end
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (grant != 2'b00) state_next = ST_RAISE;
      ST_RAISE: if (bar_up || timed_out) state_next = ST_PASS;
      ST_PASS:  if (car_pass || timed_out) state_next = ST_LOWER;
      ST_LOWER: begin
        if (bar_down)       state_next = ST_IDLE;
        else if (timed_out) state_next = ST_FAULT;
      end
      ST_FAULT: state_next = ST_FAULT;
      default:  state_next = ST_IDLE;
    endcase
    // A raise timeout skips PASS and goes straight to lowering
    if (state == ST_RAISE && !bar_up && timed_out) state_next = ST_LOWER;
  end

  always_comb begin
    last_in_next = last_in;
    count_next   = count;
    open_next    = barrier_open;
    gin_next     = grant_in;
    gout_next    = grant_out;
    to_next      = 1'b0;
    fault_next   = fault;
    unique case (state)
      ST_IDLE: begin
        if (grant != 2'b00) begin
          gin_next     = grant[0];
          gout_next    = grant[1];
          open_next    = 1'b1;
          last_in_next = grant[0];
        end
      end
      ST_RAISE: begin
        if (!bar_up && timed_out) begin
          to_next   = 1'b1;
          open_next = 1'b0;
        end
      end
      ST_PASS: begin
        if (car_pass) begin
          open_next = 1'b0;
          if (grant_in && count != CAP)       count_next = count + CNT_W'(1);
          else if (grant_out && count != '0)  count_next = count - CNT_W'(1);
        end else if (timed_out) begin
          to_next   = 1'b1;
          open_next = 1'b0;
        end
      end
      ST_LOWER: begin
        if (bar_down) begin
          gin_next  = 1'b0;
          gout_next = 1'b0;
        end else if (timed_out) begin
          gin_next   = 1'b0;
          gout_next  = 1'b0;
          fault_next = 1'b1;
        end
      end
      ST_FAULT: begin
        open_next = 1'b0;
        gin_next  = 1'b0;
        gout_next = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Self-checking bench for parking_gate_ctrl: directed vector table, hand-written
// corner sequences, and random traffic against a phase-level lot model.
module tb_parking_gate_ctrl;
  import parking_gate_ctrl_pkg::*;

  localparam int CAP = 10;
  localparam int TO  = 16;
  localparam int CW  = 4;
  localparam int W   = 8 + CW;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_req, out_req, bar_up, bar_down, car_pass;
  logic          barrier_open, grant_in, grant_out, in_denied;
  logic [CW-1:0] count;
  logic          full, empty, timeout_err, fault;
  state_t        fsm_state;

  parking_gate_ctrl #(.CAPACITY(CAP), .CNT_W(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .in_req(in_req), .out_req(out_req),
    .bar_up(bar_up), .bar_down(bar_down), .car_pass(car_pass),
    .barrier_open(barrier_open), .grant_in(grant_in), .grant_out(grant_out),
    .in_denied(in_denied), .count(count), .full(full), .empty(empty),
    .timeout_err(timeout_err), .fault(fault), .fsm_state(fsm_state)
  );

  // ---------------- clock/reset block ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef enum {PH_WAIT, PH_OPEN, PH_CROSS, PH_CLOSE, PH_BROKEN} phase_e;
  phase_e m_phase;
  int     m_age, m_cnt, m_owner;  // owner: 0 none, 1 entry car, 2 exit car
  bit     m_served_in, m_bo, m_to, m_fault;

  task automatic model_reset();
    m_phase = PH_WAIT; m_age = 0; m_cnt = 0; m_owner = 0;
    m_served_in = 0; m_bo = 0; m_to = 0; m_fault = 0;
  endtask

  task automatic model_enter(input phase_e p);
    m_phase = p;
    m_age   = 0;
  endtask

  task automatic model_clock();
    bit want_in, want_out, expired;
    expired = (m_age + 1 == TO);
    m_to = 0;
    case (m_phase)
      PH_WAIT: begin
        want_in  = in_req && (m_cnt < CAP);
        want_out = out_req && (m_cnt > 0);
        if (want_in && want_out) m_owner = m_served_in ? 2 : 1;
        else if (want_in)        m_owner = 1;
        else if (want_out)       m_owner = 2;
        else                     m_owner = 0;
        if (m_owner != 0) begin
          m_served_in = (m_owner == 1);
          m_bo = 1;
          model_enter(PH_OPEN);
        end
      end
      PH_OPEN: begin
        if (bar_up) model_enter(PH_CROSS);
        else if (expired) begin m_to = 1; m_bo = 0; model_enter(PH_CLOSE); end
        else m_age++;
      end
      PH_CROSS: begin
        if (car_pass) begin
          m_cnt = (m_owner == 1) ? ((m_cnt + 1 > CAP) ? CAP : m_cnt + 1)
                                 : ((m_cnt - 1 < 0) ? 0 : m_cnt - 1);
          m_bo = 0;
          model_enter(PH_CLOSE);
        end else if (expired) begin m_to = 1; m_bo = 0; model_enter(PH_CLOSE); end
        else m_age++;
      end
      PH_CLOSE: begin
        if (bar_down) begin m_owner = 0; model_enter(PH_WAIT); end
        else if (expired) begin m_owner = 0; m_fault = 1; model_enter(PH_BROKEN); end
        else m_age++;
      end
      default: begin m_owner = 0; m_bo = 0; end
    endcase
  endtask

  function automatic logic [W-1:0] exp_vec();
    logic den;
    den = (m_phase == PH_WAIT) && in_req && (m_cnt == CAP);
    return {m_bo, m_owner == 1, m_owner == 2, den, CW'(m_cnt),
            m_cnt == CAP, m_cnt == 0, m_to, m_fault};
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [W-1:0] act_vec();
    return {barrier_open, grant_in, grant_out, in_denied, count,
            full, empty, timeout_err, fault};
  endfunction

  task automatic check_q(input string tag);
    logic [W-1:0] e, a;
    e = exp_q.pop_front();
    a = act_vec();
    n_checks++;
    if (a !== e) begin
      n_errors++;
      $display("FAIL %s: outputs got %b expected %b (t=%0t)", tag, a, e, $time);
    end
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit i, input bit o, input bit u, input bit d, input bit p);
    in_req = i; out_req = o; bar_up = u; bar_down = d; car_pass = p;
  endtask

  task automatic step(input string tag);
    model_clock();
    exp_q.push_back(exp_vec());
    @(posedge clk);
    #1;
    check_q(tag);
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0);
    reset = 1'b1;
    #1;
    model_reset();
    exp_q.push_back(exp_vec());
    check_q("reset_model");
    check_val("reset_outputs", 32'(act_vec()), 32'(12'b0000_0000_0100));
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic lane_cycle(input bit entry);
    drive(entry, !entry, 0, 0, 0); step("cyc_req");
    drive(0, 0, 1, 0, 0);          step("cyc_up");
    drive(0, 0, 0, 0, 1);          step("cyc_pass");
    drive(0, 0, 0, 1, 0);          step("cyc_down");
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic tie_cycle(input bit want_in, input string tag);
    drive(1, 1, 0, 0, 0); step(tag);
    check_val({tag, "_gin"}, 32'(grant_in), 32'(want_in));
    check_val({tag, "_gout"}, 32'(grant_out), 32'(!want_in));
    drive(0, 0, 1, 0, 0); step(tag);
    drive(0, 0, 0, 0, 1); step(tag);
    drive(0, 0, 0, 1, 0); step(tag);
    drive(0, 0, 0, 0, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit rq_in, rq_out, up, down, pass;
    bit e_bo, e_gin, e_gout;
    int e_cnt;
    bit e_to;
  } vec_t;
  vec_t tbl[13];

  function automatic vec_t mk(input bit a, b, c, d, e, f, g, h, input int n, input bit t);
    vec_t v;
    v.rq_in = a; v.rq_out = b; v.up = c; v.down = d; v.pass = e;
    v.e_bo = f; v.e_gin = g; v.e_gout = h; v.e_cnt = n; v.e_to = t;
    return v;
  endfunction

  initial begin
    int n_to;
    int quiet;
    int broken_age;
    //           in out up dn ps  bo gi go cnt to
    tbl[0]  = mk(1, 0, 0, 0, 0,  1, 1, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0,  1, 1, 0, 0, 0);
    tbl[2]  = mk(0, 0, 1, 0, 0,  1, 1, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0,  1, 1, 0, 0, 0);
    tbl[4]  = mk(0, 0, 0, 0, 1,  0, 1, 0, 1, 0);
    tbl[5]  = mk(0, 0, 0, 0, 0,  0, 1, 0, 1, 0);
    tbl[6]  = mk(0, 0, 0, 1, 0,  0, 0, 0, 1, 0);
    tbl[7]  = mk(0, 0, 0, 0, 1,  0, 0, 0, 1, 0);
    tbl[8]  = mk(0, 1, 0, 0, 0,  1, 0, 1, 1, 0);
    tbl[9]  = mk(0, 0, 1, 0, 0,  1, 0, 1, 1, 0);
    tbl[10] = mk(0, 0, 0, 0, 1,  0, 0, 1, 0, 0);
    tbl[11] = mk(0, 0, 0, 1, 0,  0, 0, 0, 0, 0);
    tbl[12] = mk(0, 1, 0, 0, 0,  0, 0, 0, 0, 0);

    do_reset();
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].rq_in, tbl[i].rq_out, tbl[i].up, tbl[i].down, tbl[i].pass);
      step("tbl_model");
      check_val($sformatf("tbl_row%0d", i),
                32'({barrier_open, grant_in, grant_out, count, timeout_err}),
                32'({tbl[i].e_bo, tbl[i].e_gin, tbl[i].e_gout, CW'(tbl[i].e_cnt), tbl[i].e_to}));
    end

    // Fill the lot, then an eleventh car is refused
    do_reset();
    repeat (10) lane_cycle(1);
    check_val("fill_count", 32'(count), 32'(CAP));
    check_val("fill_full", 32'(full), 32'd1);
    drive(1, 0, 0, 0, 0);
    repeat (3) step("fill_11th");
    check_val("fill_11th_grant", 32'({grant_in, barrier_open}), 32'd0);
    check_val("fill_11th_denied", 32'(in_denied), 32'd1);
    check_val("fill_11th_count", 32'(count), 32'(CAP));

    // Ties at count 5 alternate entry, exit, entry
    do_reset();
    repeat (6) lane_cycle(1);
    lane_cycle(0);
    check_val("tie_start_count", 32'(count), 32'd5);
    tie_cycle(1, "tie1");
    tie_cycle(0, "tie2");
    tie_cycle(1, "tie3");
    check_val("tie_end_count", 32'(count), 32'd6);

    // Exit request with an empty lot is ignored
    do_reset();
    drive(0, 1, 0, 0, 0);
    repeat (3) step("empty_out");
    check_val("empty_out_bo", 32'({barrier_open, grant_out}), 32'd0);
    check_val("empty_out_count", 32'(count), 32'd0);

    // PASS timeout: car_pass withheld
    do_reset();
    drive(1, 0, 0, 0, 0); step("pto_req");
    drive(0, 0, 1, 0, 0); step("pto_up");
    drive(0, 0, 0, 0, 0);
    n_to = 0;
    repeat (TO) begin step("pto_wait"); n_to += int'(timeout_err); end
    check_val("pto_pulses", 32'(n_to), 32'd1);
    check_val("pto_bo", 32'(barrier_open), 32'd0);
    check_val("pto_state", 32'(fsm_state), 32'(ST_LOWER));
    check_val("pto_count", 32'(count), 32'd0);
    drive(0, 0, 0, 1, 0); step("pto_down");
    check_val("pto_to_clear", 32'(timeout_err), 32'd0);

    // RAISE timeout: bar_up never arrives
    do_reset();
    drive(1, 0, 0, 0, 0); step("rto_req");
    drive(0, 0, 0, 0, 0);
    n_to = 0;
    repeat (TO) begin step("rto_wait"); n_to += int'(timeout_err); end
    check_val("rto_pulses", 32'(n_to), 32'd1);
    check_val("rto_state", 32'(fsm_state), 32'(ST_LOWER));

    // LOWER timeout: sticky fault, requests ignored, reset recovers
    do_reset();
    drive(1, 0, 0, 0, 0); step("flt_req");
    drive(0, 0, 1, 0, 0); step("flt_up");
    drive(0, 0, 0, 0, 1); step("flt_pass");
    drive(0, 0, 0, 0, 0);
    repeat (TO) step("flt_wait");
    check_val("flt_fault", 32'(fault), 32'd1);
    check_val("flt_state", 32'(fsm_state), 32'(ST_FAULT));
    drive(1, 1, 1, 1, 1);
    repeat (4) step("flt_ignore");
    check_val("flt_ignore_out", 32'({barrier_open, grant_in, grant_out, fault}), 32'd1);
    do_reset();
    check_val("flt_reset_state", 32'(fsm_state), 32'(ST_IDLE));

    // Random traffic against the model
    do_reset();
    quiet = 0;
    broken_age = 0;
    for (int c = 0; c < 4000; c++) begin
      if (quiet > 0) begin
        drive($urandom_range(0, 1), $urandom_range(0, 1), 0, 0, 0);
        quiet--;
      end else begin
        drive($urandom_range(0, 1), $urandom_range(0, 1),
              $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 3) == 0);
        if ($urandom_range(0, 59) == 0) quiet = $urandom_range(8, 20);
      end
      step("rand");
      broken_age = (m_phase == PH_BROKEN) ? broken_age + 1 : 0;
      if (broken_age > 5 || $urandom_range(0, 799) == 0) begin
        do_reset();
        broken_age = 0;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
